uart_tx_frame: RTL and testbench



---
 rtl/uart_pkg.sv | 39 +++
 rtl/uart_tx_frame_if.sv | 13 +
 rtl/uart_bit_timer.sv | 33 +++
 rtl/uart_tx_frame.sv | 155 +++++++++++++++
 tb/tb_uart_tx_frame.sv | 312 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared UART types and helpers for the transmitter and the future receiver.
// Optional macro UART_TX_BREAK_EN adds the StBreak transmitter state.
package uart_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop
`ifdef UART_TX_BREAK_EN
    , StBreak
`endif
  } tx_state_t;

  typedef enum logic [1:0] {
    PAR_NONE = 2'b00,
    PAR_EVEN = 2'b01,
    PAR_ODD  = 2'b10,
    PAR_MARK = 2'b11
  } parity_t;

  // Tick counter width able to hold two full bit periods.
  function automatic int unsigned tick_w(input int unsigned oversample);
    return $clog2(2 * oversample);
  endfunction

  function automatic logic parity_bit(input parity_t mode, input logic word_xor);
    logic p;
    unique case (mode)
      PAR_EVEN: p = word_xor;
      PAR_ODD:  p = ~word_xor;
      PAR_MARK: p = 1'b1;
      default:  p = 1'b0;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/uart_tx_frame_if.sv
// Word handshake between the packet/FIFO logic (master) and the UART transmitter (slave).
interface uart_tx_frame_if #(
  parameter int unsigned DBITS = 8
) ();
  logic             s_valid;
  logic             s_ready;
  logic [DBITS-1:0] s_data;
  logic [1:0]       parity_mode;
  logic             stop2;

  modport master (output s_valid, s_data, parity_mode, stop2, input s_ready);
  modport slave  (input s_valid, s_data, parity_mode, stop2, output s_ready);
endinterface

// File: rtl/uart_bit_timer.sv
// Counts sample_tick pulses and strobes bit_end after one or two bit periods.
module uart_bit_timer
  import uart_pkg::*;
#(
  parameter int unsigned OVERSAMPLE = 16
) (
  input  logic clk_100MHz,
  input  logic reset_n,
  input  logic sample_tick,
  input  logic enable,
  input  logic clear,
  input  logic two_periods,
  output logic bit_end
);
  localparam int unsigned TW = tick_w(OVERSAMPLE);
  localparam logic [TW-1:0] Last1 = TW'(OVERSAMPLE - 1);
  localparam logic [TW-1:0] Last2 = TW'(2 * OVERSAMPLE - 1);

  logic [TW-1:0] cnt_q;

  assign bit_end = enable && sample_tick && (cnt_q == (two_periods ? Last2 : Last1));

  always_ff @(posedge clk_100MHz or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else if (clear) begin
      cnt_q <= '0;
    end else if (enable && sample_tick) begin
      cnt_q <= bit_end ? '0 : cnt_q + TW'(1);
    end
  end

endmodule

// File: rtl/uart_tx_frame.sv
// UART transmitter: start, DBITS data LSB first, optional parity, 1 or 2 stop bits.
// Optional macro UART_TX_BREAK_EN adds the send_break input and a line-break state.
module uart_tx_frame
  import uart_pkg::*;
#(
  parameter int unsigned DBITS      = 8,
  parameter int unsigned OVERSAMPLE = 16
) (
  input  logic           clk_100MHz,
  input  logic           reset_n,
  input  logic           sample_tick,
`ifdef UART_TX_BREAK_EN
  input  logic           send_break,
`endif
  uart_tx_frame_if.slave s,
  output logic           tx,
  output logic           busy,
  output logic           tx_done
);
  localparam logic [3:0] DataLast = 4'(DBITS - 1);
`ifdef UART_TX_BREAK_EN
  localparam logic [3:0] BrkLast  = 4'(DBITS + 2);
`endif

  tx_state_t        state_q;
  logic [DBITS-1:0] shift_q;
  logic [3:0]       bit_cnt_q;
  logic             par_en_q;
  logic             par_bit_q;
  logic             stop2_q;
  logic             tx_q;
  logic             tx_done_q;
  logic             bit_end;
  logic             accept;
  logic             brk_req;
`ifdef UART_TX_BREAK_EN
  logic             brk_stop_q;
  assign brk_req = send_break;
`else
  assign brk_req = 1'b0;
`endif

  // The end of the last stop tick doubles as an accept slot for back-to-back frames.
  assign s.s_ready = (state_q == StIdle && !brk_req) || (state_q == StStop && bit_end);
  assign accept    = s.s_valid && s.s_ready;

  uart_bit_timer #(
    .OVERSAMPLE(OVERSAMPLE)
  ) u_bit_timer (
    .clk_100MHz (clk_100MHz),
    .reset_n    (reset_n),
    .sample_tick(sample_tick),
    .enable     (state_q != StIdle),
    .clear      (accept || (state_q == StIdle && brk_req)),
    .two_periods(state_q == StStop && stop2_q),
    .bit_end    (bit_end)
  );

  always_ff @(posedge clk_100MHz or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= StIdle;
      shift_q    <= '0;
      bit_cnt_q  <= '0;
      par_en_q   <= 1'b0;
      par_bit_q  <= 1'b0;
      stop2_q    <= 1'b0;
      tx_q       <= 1'b1;
      tx_done_q  <= 1'b0;
`ifdef UART_TX_BREAK_EN
      brk_stop_q <= 1'b0;
`endif
    end else begin
      tx_done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
`ifdef UART_TX_BREAK_EN
          if (brk_req) begin
            state_q   <= StBreak;
            tx_q      <= 1'b0;
            bit_cnt_q <= '0;
          end
`endif
        end
        StStart: begin
          if (bit_end) begin
            state_q   <= StData;
            tx_q      <= shift_q[0];
            bit_cnt_q <= '0;
          end
        end
        StData: begin
          if (bit_end) begin
            if (bit_cnt_q == DataLast) begin
              if (par_en_q) begin
                state_q <= StParity;
                tx_q    <= par_bit_q;
              end else begin
                state_q <= StStop;
                tx_q    <= 1'b1;
              end
            end else begin
              shift_q   <= shift_q >> 1;
              tx_q      <= shift_q[1];
              bit_cnt_q <= bit_cnt_q + 4'd1;
            end
          end
        end
        StParity: begin
          if (bit_end) begin
            state_q <= StStop;
            tx_q    <= 1'b1;
          end
        end
        StStop: begin
          if (bit_end) begin
            state_q   <= StIdle;
            tx_done_q <= 1'b1;
          end
        end
`ifdef UART_TX_BREAK_EN
        // Hold the line low for at least DBITS+3 bit periods, then one stop period high.
        StBreak: begin
          if (bit_end) begin
            if (brk_stop_q) begin
              state_q    <= StIdle;
              brk_stop_q <= 1'b0;
            end else if (bit_cnt_q >= BrkLast && !send_break) begin
              brk_stop_q <= 1'b1;
              tx_q       <= 1'b1;
            end else if (bit_cnt_q < BrkLast) begin
              bit_cnt_q <= bit_cnt_q + 4'd1;
            end
          end
        end
`endif
        default: state_q <= StIdle;
      endcase

      // Accept overrides the StStop exit so a queued word starts with no idle gap.
      if (accept) begin
        state_q   <= StStart;
        tx_q      <= 1'b0;
        shift_q   <= s.s_data;
        par_en_q  <= (s.parity_mode != PAR_NONE);
        par_bit_q <= parity_bit(parity_t'(s.parity_mode), ^s.s_data);
        stop2_q   <= s.stop2;
      end
    end
  end

  assign tx      = tx_q;
  assign busy    = (state_q != StIdle);
  assign tx_done = tx_done_q;

endmodule

// File: tb/tb_uart_tx_frame.sv
// Bench for uart_tx_frame: tick-indexed frame model checked against the DUT every cycle.
module tb_uart_tx_frame;
  localparam int unsigned DBITS = 8;
  localparam int unsigned OS    = 16;

  logic clk_100MHz  = 1'b0;
  logic reset_n     = 1'b0;
  logic sample_tick = 1'b0;
  logic tx;
  logic busy;
  logic tx_done;
`ifdef UART_TX_BREAK_EN
  logic send_break  = 1'b0;
`endif

  int checks = 0;
  int errors = 0;

  uart_tx_frame_if #(.DBITS(DBITS)) bif ();

  uart_tx_frame #(
    .DBITS     (DBITS),
    .OVERSAMPLE(OS)
  ) dut (
    .clk_100MHz (clk_100MHz),
    .reset_n    (reset_n),
    .sample_tick(sample_tick),
`ifdef UART_TX_BREAK_EN
    .send_break (send_break),
`endif
    .s          (bif),
    .tx         (tx),
    .busy       (busy),
    .tx_done    (tx_done)
  );

  always #5 clk_100MHz = ~clk_100MHz;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h want %0h", name, $time, got, exp);
    end
  endtask

  // Frame as a bit list indexed by bit period; unused upper bits stay 1 (stop/idle).
  function automatic void build(input logic [DBITS-1:0] d, input logic [1:0] pm,
                                input logic st2, output logic [15:0] bits, output int len);
    int n;
    bits    = '1;
    bits[0] = 1'b0;
    for (int i = 0; i < DBITS; i++) bits[4'(1 + i)] = d[i];
    n = 1 + DBITS;
    if (pm != 2'b00) begin
      if (pm == 2'b11)      bits[4'(n)] = 1'b1;
      else if (pm == 2'b01) bits[4'(n)] = 1'($countones(d) % 2);
      else                  bits[4'(n)] = 1'(1 - ($countones(d) % 2));
      n++;
    end
    len = OS * (n + (st2 ? 2 : 1));
  endfunction

  // Reference model: ticks since the frame's accept edge select the expected line level.
  logic [15:0] m_bits = '1;
  int          m_len  = 0;
  int          m_k    = 0;
  bit          m_busy = 1'b0;
  bit          m_brk  = 1'b0;
  bit          exp_done = 1'b0;
  int          gticks = 0;

  task automatic model_start();
    build(bif.s_data, bif.parity_mode, bif.stop2, m_bits, m_len);
    m_busy = 1'b1;
    m_brk  = 1'b0;
    m_k    = 0;
  endtask

  always @(posedge clk_100MHz) begin
    bit was_brk;
    if (!reset_n) begin
      m_busy   = 1'b0;
      m_brk    = 1'b0;
      m_k      = 0;
      exp_done = 1'b0;
    end else begin
      exp_done = 1'b0;
      if (sample_tick) gticks++;
      if (!m_busy) begin
`ifdef UART_TX_BREAK_EN
        if (send_break) begin
          m_bits = '1;
          for (int i = 0; i < DBITS + 3; i++) m_bits[4'(i)] = 1'b0;
          m_len  = (DBITS + 4) * OS;
          m_busy = 1'b1;
          m_brk  = 1'b1;
          m_k    = 0;
        end else
`endif
        if (bif.s_valid) model_start();
      end else if (sample_tick) begin
        m_k++;
        if (m_k == m_len) begin
          was_brk  = m_brk;
          exp_done = !was_brk;
          m_busy   = 1'b0;
          m_brk    = 1'b0;
          if (!was_brk && bif.s_valid) model_start();
        end
      end
    end
  end

  int done_q[$];
  int last_done_tick = 0;
  int done_cnt = 0;
  int rdy_cnt  = 0;

  always @(negedge clk_100MHz) begin
    logic er;
    if (!reset_n) begin
      chk("rst_tx", 32'(tx), 32'd1);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_tx_done", 32'(tx_done), 32'd0);
    end else begin
      er = !m_busy || (!m_brk && sample_tick && (m_k == m_len - 1));
`ifdef UART_TX_BREAK_EN
      if (!m_busy && send_break) er = 1'b0;
`endif
      chk("tx", 32'(tx), 32'(m_busy ? m_bits[4'(m_k / OS)] : 1'b1));
      chk("busy", 32'(busy), 32'(m_busy));
      chk("tx_done", 32'(tx_done), 32'(exp_done));
      chk("s_ready", 32'(bif.s_ready), 32'(er));
      if (tx_done === 1'b1) begin
        done_cnt++;
        last_done_tick = gticks;
        done_q.push_back(gticks);
      end
      if (bif.s_ready === 1'b1 && busy === 1'b1) rdy_cnt++;
    end
  end

  initial begin
    int ph = 0;
    forever begin
      @(posedge clk_100MHz);
      #1;
      sample_tick = (ph == 3);
      ph = (ph + 1) % 4;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog at %0t: got no finish want finish", $time);
    $fatal(1);
  end

  task automatic step();
    @(posedge clk_100MHz);
    #1;
  endtask

  task automatic wait_accept(input string name);
    bit ok = 1'b0;
    for (int n = 0; n < 3000 && !ok; n++) begin
      @(negedge clk_100MHz);
      if (bif.s_ready === 1'b1 && bif.s_valid) ok = 1'b1;
    end
    if (!ok) chk({name, "_accept_timeout"}, 32'd0, 32'd1);
    step();
  endtask

  task automatic wait_idle(input string name);
    bit ok = 1'b0;
    for (int n = 0; n < 3000 && !ok; n++) begin
      @(negedge clk_100MHz);
      if (!m_busy) ok = 1'b1;
    end
    if (!ok) chk({name, "_idle_timeout"}, 32'd0, 32'd1);
    step();
  endtask

  int start_tick = 0;

  // Accept one word, then scramble the inputs to prove they were latched.
  task automatic begin_frame(input logic [7:0] d, input logic [1:0] pm, input logic st2,
                             input string name);
    bif.s_valid     = 1'b1;
    bif.s_data      = d;
    bif.parity_mode = pm;
    bif.stop2       = st2;
    wait_accept(name);
    start_tick      = gticks;
    bif.s_valid     = 1'b0;
    bif.s_data      = 8'($urandom);
    bif.parity_mode = 2'($urandom);
    bif.stop2       = 1'($urandom);
  endtask

  task automatic frame(input logic [7:0] d, input logic [1:0] pm, input logic st2,
                       input int exp_len, input string name);
    begin_frame(d, pm, st2, name);
    wait_idle(name);
    chk({name, "_len"}, 32'(last_done_tick - start_tick), 32'(exp_len));
  endtask

  initial begin
    logic [15:0] b;
    int          l;
    int          d0;
    bif.s_valid     = 1'b0;
    bif.s_data      = '0;
    bif.parity_mode = 2'b00;
    bif.stop2       = 1'b0;

    // Hand-computed frames pin the model.
    build(8'h55, 2'b00, 1'b0, b, l);
    chk("pin55_len", 32'(l), 32'd160);
    chk("pin55_bits", 32'(b[9:0]), 32'h2AA);
    build(8'hA7, 2'b01, 1'b0, b, l);
    chk("pinA7_even", 32'(b[9]), 32'd1);
    chk("pinA7_len", 32'(l), 32'd176);
    build(8'hA7, 2'b10, 1'b0, b, l);
    chk("pinA7_odd", 32'(b[9]), 32'd0);
    build(8'h00, 2'b11, 1'b0, b, l);
    chk("pin00_mark", 32'(b[9]), 32'd1);
    build(8'hFF, 2'b00, 1'b1, b, l);
    chk("pinFF_stop2_len", 32'(l), 32'd176);

    repeat (5) @(posedge clk_100MHz);
    #1;
    reset_n = 1'b1;
    step();

    frame(8'h55, 2'b00, 1'b0, 160, "f55");
    frame(8'hA7, 2'b01, 1'b0, 176, "fA7_even");
    frame(8'hA7, 2'b10, 1'b0, 176, "fA7_odd");
    frame(8'h00, 2'b11, 1'b0, 176, "f00_mark");
    frame(8'hFF, 2'b00, 1'b1, 176, "fFF_stop2");

    // Back-to-back with s_valid held high.
    done_q.delete();
    bif.s_valid     = 1'b1;
    bif.s_data      = 8'h31;
    bif.parity_mode = 2'b00;
    bif.stop2       = 1'b0;
    wait_accept("b2b_first");
    start_tick      = gticks;
    rdy_cnt         = 0;
    bif.s_data      = 8'h32;
    wait_accept("b2b_second");
    chk("b2b_ready_first", 32'(rdy_cnt), 32'd1);
    bif.s_valid = 1'b0;
    rdy_cnt     = 0;
    wait_idle("b2b");
    chk("b2b_ready_second", 32'(rdy_cnt), 32'd1);
    chk("b2b_done_count", 32'(done_q.size()), 32'd2);
    if (done_q.size() == 2) begin
      chk("b2b_first_len", 32'(done_q[0] - start_tick), 32'd160);
      chk("b2b_spacing", 32'(done_q[1] - done_q[0]), 32'd160);
    end

    // Reset during data bit 3.
    begin_frame(8'hC3, 2'b00, 1'b0, "rst_frame");
    for (int n = 0; n < 3000 && m_k < 4 * OS + 5; n++) @(negedge clk_100MHz);
    chk("rst_reached_bit3", 32'(m_k >= 4 * OS + 5), 32'd1);
    step();
    d0 = done_cnt;
    reset_n = 1'b0;
    #1;
    chk("async_tx", 32'(tx), 32'd1);
    chk("async_busy", 32'(busy), 32'd0);
    repeat (3) step();
    reset_n = 1'b1;
    repeat (40) step();
    chk("rst_no_done", 32'(done_cnt), 32'(d0));
    frame(8'h3C, 2'b10, 1'b0, 176, "post_rst");

    // Randomized traffic, including back-to-back accepts at stop ends.
    for (int c = 0; c < 24000; c++) begin
      bif.s_valid     = ($urandom_range(0, 2) == 0);
      bif.s_data      = 8'($urandom);
      bif.parity_mode = 2'($urandom);
      bif.stop2       = 1'($urandom);
      step();
    end
    bif.s_valid = 1'b0;
    wait_idle("rand");

`ifdef UART_TX_BREAK_EN
    // One-cycle break pulse with a word already queued.
    send_break      = 1'b1;
    bif.s_valid     = 1'b1;
    bif.s_data      = 8'h5A;
    bif.parity_mode = 2'b00;
    bif.stop2       = 1'b0;
    step();
    start_tick = gticks;
    send_break = 1'b0;
    wait_accept("break");
    chk("break_len", 32'(gticks - start_tick), 32'd192);
    bif.s_valid = 1'b0;
    wait_idle("break_word");
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
